rocev2_mem_responder: RTL and testbench
=======================================

Name: rocev2_mem_responder

Overview:
- Host-memory responder for the RoCEv2 stack's memory interface, on the opposite end of rocev2_top's mem_write_cmd/mem_write_data outputs and mem_read_cmd output/mem_read_data input.
- Executes write commands into an internal 512-bit-wide RAM and answers read commands with 64-byte beats.
- Used as the memory model in cocotb benches and as the on-chip buffer in loopback builds.

Parameters:
- ADDR_WORDS_LOG2, 10, log2 of RAM depth in 64-byte words (default 64 KiB).
- DATA_W, 512, stream data width; fixed; tkeep width is DATA_W/8.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- s_axis_mem_write_cmd_tdata  in  96  [63:0] byte address, [95:64] byte length
- s_axis_mem_write_cmd_tvalid  in  1  write cmd valid
- s_axis_mem_write_cmd_tready  out  1  write cmd ready
- s_axis_mem_write_data_tdata  in  512  write payload
- s_axis_mem_write_data_tkeep  in  64  byte enables
- s_axis_mem_write_data_tvalid  in  1  payload valid
- s_axis_mem_write_data_tready  out  1  payload ready
- s_axis_mem_read_cmd_tdata  in  96  same layout as write cmd
- s_axis_mem_read_cmd_tvalid  in  1  read cmd valid
- s_axis_mem_read_cmd_tready  out  1  read cmd ready
- m_axis_mem_read_data_tdata  out  512  read payload
- m_axis_mem_read_data_tkeep  out  64  valid bytes
- m_axis_mem_read_data_tlast  out  1  last beat of command
- m_axis_mem_read_data_tvalid  out  1  payload valid
- m_axis_mem_read_data_tready  in  1  payload ready
- wr_cmd_count  out  32  accepted write commands
- rd_cmd_count  out  32  accepted read commands
- unaligned_count  out  32  commands with addr[5:0] != 0

Behaviour:
- Reset (async assert, sync release): all tvalid/tready 0, tlast 0, tkeep 0, counters 0, both FSMs idle. RAM contents not reset.
- Reset mid-operation: in-flight commands are discarded; no beat is emitted after reset asserts.
- Beat count = (len + 63) >> 6, 27-bit unsigned.
- Word index = addr[6 +: ADDR_WORDS_LOG2]. It wraps modulo depth, both at command start and while incrementing.
- addr[5:0] is ignored (aligned down); unaligned_count increments once per such command.
- Counters saturate at 0xFFFFFFFF.
- Write FSM W_IDLE -> W_DATA:
  - W_IDLE: cmd_tready=1, data_tready=0.
  - On cmd handshake: latch word index and beats; wr_cmd_count++. Go to W_DATA if beats>0, else stay (zero-length write consumes no data).
  - W_DATA: cmd_tready=0, data_tready=1. Each data handshake writes RAM[idx] with per-byte enable tkeep[i], then idx++, beats--.
  - On the handshake with beats==1, return to W_IDLE. cmd_tready rises the next cycle.
  - Data tlast is not present; beat count alone delimits.
- Read FSM R_IDLE -> R_RUN:
  - R_IDLE: cmd_tready=1. On handshake: latch index, beats, last-beat keep; rd_cmd_count++. Zero length stays idle with no output.
  - R_RUN: cmd_tready=0. Issue one RAM read per cycle while the output skid buffer reports space for the in-flight read (credit = free slots minus reads in flight).
  - RAM read latency is 1 cycle. Command handshake to first tvalid is 2 cycles when the output is ready.
  - Sustained throughput is 1 beat/cycle under continuous tready.
  - Return to R_IDLE after the last read is issued. The next command may be accepted while prior beats drain; output order is preserved.
- Output beats:
  - Non-last beats: tkeep = all ones, tlast = 0.
  - Last beat: tlast = 1, tkeep = (len[5:0]==0) ? all ones : (1<<len[5:0]) - 1.
- Output stability: tdata/tkeep/tlast are held stable while tvalid && !tready. tvalid never drops without a handshake.
- RAM is simple dual-port: write port owned by the write FSM, read port by the read FSM.
- Same-cycle read and write to the same word: read-first (old data returned).
- Write and read commands are independent; no ordering is enforced between them.

Decomposition:
- Package rocev2_mem_pkg:
  - mem_cmd_t struct {len[31:0], addr[63:0]} and its width constant 96.
  - BEAT_BYTES=64 and the BEAT_SHIFT=6 constant.
  - Function last_keep(len[5:0]).
- Sub-module axis_skid_buf: 2-entry 512+64+1-bit register FIFO with full/almost-full outputs for read-credit accounting.
- RAM is inferred inline.

Test Plan:
- Write 128 B at 0x1000 with all-ones tkeep, data A/B; then read 128 B at 0x1000 -> 2 beats A, B; beat 2 tlast=1, tkeep all ones; wr_cmd_count=1, rd_cmd_count=1.
- Read 100 B at 0x1000 -> 2 beats; last tkeep=0x0000000FFFFFFFFF, tlast=1.
- Random 50% tready backpressure on a 16-beat read -> exactly 16 beats in address order, no drop/dup, data stable while stalled.
- Zero-length write followed by a 64 B write -> first consumes no data; second write lands correctly; wr_cmd_count=2.
- Address 0x1_0003_FFC0 with default depth: 128 B write/read wraps word 1023 -> 0; address 0x1005 counts unaligned_count=1 and acts on 0x1000.
- Assert ap_rst_n low during beat 3 of an 8-beat read -> tvalid 0 immediately, counters 0; after release a new read returns the correct first beat.

Source files
------------

// File: rtl/rocev2_mem_responder_pkg.sv
// Shared types and helpers for the RoCEv2 host-memory responder.
// Command layout, beat geometry and saturating counter arithmetic.
package rocev2_mem_pkg;

    localparam int CMD_W      = 96;
    localparam int BEAT_BYTES = 64;
    localparam int BEAT_SHIFT = 6;

    // Packed MSB-first, so len lands on [95:64] and addr on [63:0].
    typedef struct packed {
        logic [31:0] len;
        logic [63:0] addr;
    } mem_cmd_t;

    function automatic logic [63:0] last_keep(input logic [5:0] len_lo);
        logic [63:0] k;
        if (len_lo == 6'd0) k = '1;
        else                k = (64'd1 << len_lo) - 64'd1;
        return k;
    endfunction

    function automatic logic [26:0] beat_count(input logic [31:0] len);
        logic [32:0] s;
        s = {1'b0, len} + 33'd63;
        return s[32:6];
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, c} + {31'd0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/rocev2_mem_responder_if.sv
// AXI-Stream bundle between the RoCEv2 stack (master) and the memory responder (slave).
interface rocev2_mem_responder_if #(parameter int DATA_W = 512);
    import rocev2_mem_pkg::*;

    localparam int KW = DATA_W / 8;

    logic [CMD_W-1:0]  s_axis_mem_write_cmd_tdata;
    logic              s_axis_mem_write_cmd_tvalid;
    logic              s_axis_mem_write_cmd_tready;
    logic [DATA_W-1:0] s_axis_mem_write_data_tdata;
    logic [KW-1:0]     s_axis_mem_write_data_tkeep;
    logic              s_axis_mem_write_data_tvalid;
    logic              s_axis_mem_write_data_tready;
    logic [CMD_W-1:0]  s_axis_mem_read_cmd_tdata;
    logic              s_axis_mem_read_cmd_tvalid;
    logic              s_axis_mem_read_cmd_tready;
    logic [DATA_W-1:0] m_axis_mem_read_data_tdata;
    logic [KW-1:0]     m_axis_mem_read_data_tkeep;
    logic              m_axis_mem_read_data_tlast;
    logic              m_axis_mem_read_data_tvalid;
    logic              m_axis_mem_read_data_tready;

    modport slave (
        input  s_axis_mem_write_cmd_tdata, s_axis_mem_write_cmd_tvalid,
        output s_axis_mem_write_cmd_tready,
        input  s_axis_mem_write_data_tdata, s_axis_mem_write_data_tkeep, s_axis_mem_write_data_tvalid,
        output s_axis_mem_write_data_tready,
        input  s_axis_mem_read_cmd_tdata, s_axis_mem_read_cmd_tvalid,
        output s_axis_mem_read_cmd_tready,
        output m_axis_mem_read_data_tdata, m_axis_mem_read_data_tkeep,
        output m_axis_mem_read_data_tlast, m_axis_mem_read_data_tvalid,
        input  m_axis_mem_read_data_tready
    );

    modport master (
        output s_axis_mem_write_cmd_tdata, s_axis_mem_write_cmd_tvalid,
        input  s_axis_mem_write_cmd_tready,
        output s_axis_mem_write_data_tdata, s_axis_mem_write_data_tkeep, s_axis_mem_write_data_tvalid,
        input  s_axis_mem_write_data_tready,
        output s_axis_mem_read_cmd_tdata, s_axis_mem_read_cmd_tvalid,
        input  s_axis_mem_read_cmd_tready,
        input  m_axis_mem_read_data_tdata, m_axis_mem_read_data_tkeep,
        input  m_axis_mem_read_data_tlast, m_axis_mem_read_data_tvalid,
        output m_axis_mem_read_data_tready
    );

endinterface

// File: rtl/rocev2_mem_responder_axis_skid_buf.sv
// Two-entry register FIFO on the read-data output; full/almost-full feed read credit.
module axis_skid_buf #(
    parameter int W = 577
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_afull
);
    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign w_pop = o_valid && i_ready;

    // Storage is reset so tkeep/tlast read back as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_dout  = r_mem[r_rp];
    assign o_full  = (r_cnt == 2'd2);
    assign o_afull = (r_cnt != 2'd0);

endmodule

// File: rtl/rocev2_mem_responder.sv
// Host-memory responder: executes write commands into a 512-bit RAM and
// streams read commands back as 64-byte beats with tlast/tkeep on the final beat.
module rocev2_mem_responder
    import rocev2_mem_pkg::*;
#(
    parameter int ADDR_WORDS_LOG2 = 10,
    parameter int DATA_W          = 512
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    rocev2_mem_responder_if.slave mem,
    output logic [31:0]           wr_cmd_count,
    output logic [31:0]           rd_cmd_count,
    output logic [31:0]           unaligned_count
);
    localparam int KW    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;
    localparam int SKW   = DATA_W + KW + 1;
    localparam logic [ADDR_WORDS_LOG2-1:0] IDX_ONE   = 1;
    localparam logic [26:0]                BEATS_ONE = 27'd1;

    typedef enum logic {W_IDLE, W_DATA} wr_state_t;
    typedef enum logic {R_IDLE, R_RUN}  rd_state_t;

    logic [DATA_W-1:0]          r_ram [DEPTH];
    logic                       r_live;
    mem_cmd_t                   w_wcmd, w_rcmd;
    logic                       w_unused;

    wr_state_t                  r_wst, w_wst_nxt;
    logic [ADDR_WORDS_LOG2-1:0] r_widx;
    logic [26:0]                r_wbeats;
    logic                       w_wcmd_rdy, w_wdat_rdy, w_wcmd_hs, w_wdat_hs;

    rd_state_t                  r_rst, w_rst_nxt;
    logic [ADDR_WORDS_LOG2-1:0] r_ridx;
    logic [26:0]                r_rbeats;
    logic [KW-1:0]              r_rkeep;
    logic                       w_rcmd_rdy, w_rcmd_hs, w_rd_issue, w_credit_ok;

    logic                       r_rd_vld, r_rd_last;
    logic [KW-1:0]              r_rd_keep;
    logic [DATA_W-1:0]          r_rd_data;
    logic                       w_out_vld, w_pop, w_sk_full, w_sk_afull;
    logic [SKW-1:0]             w_out;
    logic [1:0]                 w_sk_space;
    logic [1:0]                 w_un_inc;

    assign w_wcmd   = mem.s_axis_mem_write_cmd_tdata;
    assign w_rcmd   = mem.s_axis_mem_read_cmd_tdata;
    assign w_unused = ^{w_wcmd.addr, w_rcmd.addr};

    // Holds both cmd_tready low through reset and the first cycle after release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_live <= 1'b0;
        else           r_live <= 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_wst <= W_IDLE;
        else           r_wst <= w_wst_nxt;
    end

    always_comb begin
        w_wst_nxt  = r_wst;
        w_wcmd_rdy = 1'b0;
        w_wdat_rdy = 1'b0;
        case (r_wst)
            W_IDLE: begin
                w_wcmd_rdy = r_live;
                if (r_live && mem.s_axis_mem_write_cmd_tvalid && beat_count(w_wcmd.len) != 27'd0)
                    w_wst_nxt = W_DATA;
            end
            W_DATA: begin
                w_wdat_rdy = 1'b1;
                if (mem.s_axis_mem_write_data_tvalid && r_wbeats == BEATS_ONE)
                    w_wst_nxt = W_IDLE;
            end
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    assign w_wcmd_hs = w_wcmd_rdy && mem.s_axis_mem_write_cmd_tvalid;
    assign w_wdat_hs = w_wdat_rdy && mem.s_axis_mem_write_data_tvalid;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_widx   <= '0;
            r_wbeats <= '0;
        end else if (w_wcmd_hs) begin
            r_widx   <= w_wcmd.addr[BEAT_SHIFT +: ADDR_WORDS_LOG2];
            r_wbeats <= beat_count(w_wcmd.len);
        end else if (w_wdat_hs) begin
            r_widx   <= r_widx + IDX_ONE;
            r_wbeats <= r_wbeats - BEATS_ONE;
        end
    end

    // Read credit: free skid slots plus this cycle's pop, minus the read already in flight.
    assign w_pop       = w_out_vld && mem.m_axis_mem_read_data_tready;
    assign w_sk_space  = w_sk_full ? 2'd0 : (w_sk_afull ? 2'd1 : 2'd2);
    assign w_credit_ok = ({1'b0, w_sk_space} + {2'b0, w_pop}) > {2'b0, r_rd_vld};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_rst <= R_IDLE;
        else           r_rst <= w_rst_nxt;
    end

    always_comb begin
        w_rst_nxt  = r_rst;
        w_rcmd_rdy = 1'b0;
        w_rd_issue = 1'b0;
        case (r_rst)
            R_IDLE: begin
                w_rcmd_rdy = r_live;
                if (r_live && mem.s_axis_mem_read_cmd_tvalid && beat_count(w_rcmd.len) != 27'd0)
                    w_rst_nxt = R_RUN;
            end
            R_RUN: begin
                w_rd_issue = w_credit_ok;
                if (w_credit_ok && r_rbeats == BEATS_ONE)
                    w_rst_nxt = R_IDLE;
            end
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    assign w_rcmd_hs = w_rcmd_rdy && mem.s_axis_mem_read_cmd_tvalid;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ridx    <= '0;
            r_rbeats  <= '0;
            r_rkeep   <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_keep <= '0;
        end else begin
            if (w_rcmd_hs) begin
                r_ridx   <= w_rcmd.addr[BEAT_SHIFT +: ADDR_WORDS_LOG2];
                r_rbeats <= beat_count(w_rcmd.len);
                r_rkeep  <= last_keep(w_rcmd.len[5:0]);
            end else if (w_rd_issue) begin
                r_ridx   <= r_ridx + IDX_ONE;
                r_rbeats <= r_rbeats - BEATS_ONE;
            end
            r_rd_vld  <= w_rd_issue;
            r_rd_last <= w_rd_issue && (r_rbeats == BEATS_ONE);
            r_rd_keep <= (r_rbeats == BEATS_ONE) ? r_rkeep : '1;
        end
    end

    // Simple dual-port RAM; non-blocking update gives read-first on a same-word collision.
    always_ff @(posedge ap_clk) begin
        if (w_wdat_hs) begin
            for (int b = 0; b < KW; b++)
                if (mem.s_axis_mem_write_data_tkeep[b])
                    r_ram[r_widx][b*8 +: 8] <= mem.s_axis_mem_write_data_tdata[b*8 +: 8];
        end
        if (w_rd_issue) r_rd_data <= r_ram[r_ridx];
    end

    axis_skid_buf #(.W(SKW)) u_skid (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_push  (r_rd_vld),
        .i_din   ({r_rd_last, r_rd_keep, r_rd_data}),
        .i_ready (mem.m_axis_mem_read_data_tready),
        .o_valid (w_out_vld),
        .o_dout  (w_out),
        .o_full  (w_sk_full),
        .o_afull (w_sk_afull)
    );

    assign mem.m_axis_mem_read_data_tvalid = w_out_vld;
    assign {mem.m_axis_mem_read_data_tlast,
            mem.m_axis_mem_read_data_tkeep,
            mem.m_axis_mem_read_data_tdata} = w_out;

    assign mem.s_axis_mem_write_cmd_tready  = w_wcmd_rdy;
    assign mem.s_axis_mem_write_data_tready = w_wdat_rdy;
    assign mem.s_axis_mem_read_cmd_tready   = w_rcmd_rdy;

    assign w_un_inc = {1'b0, w_wcmd_hs && (w_wcmd.addr[5:0] != 6'd0)}
                    + {1'b0, w_rcmd_hs && (w_rcmd.addr[5:0] != 6'd0)};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_cmd_count    <= '0;
            rd_cmd_count    <= '0;
            unaligned_count <= '0;
        end else begin
            wr_cmd_count    <= sat_add(wr_cmd_count, {1'b0, w_wcmd_hs});
            rd_cmd_count    <= sat_add(rd_cmd_count, {1'b0, w_rcmd_hs});
            unaligned_count <= sat_add(unaligned_count, w_un_inc);
        end
    end

endmodule

// File: tb/tb_rocev2_mem_responder.sv
// Randomized self-checking bench for rocev2_mem_responder against a word-array memory model.
module tb_rocev2_mem_responder;
    import rocev2_mem_pkg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] wr_cmd_count, rd_cmd_count, unaligned_count;

    rocev2_mem_responder_if #(.DATA_W(512)) mif ();

    rocev2_mem_responder #(.ADDR_WORDS_LOG2(10), .DATA_W(512)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .mem             (mif.slave),
        .wr_cmd_count    (wr_cmd_count),
        .rd_cmd_count    (rd_cmd_count),
        .unaligned_count (unaligned_count)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    logic [511:0] model [1024];
    beat_t        exp_q [$];
    int           vectors = 0;
    int           miscompares = 0;
    logic [31:0]  exp_wr = 0, exp_rd = 0, exp_un = 0;

    function automatic int widx(input logic [63:0] a);
        return int'((a / 64) % 1024);
    endfunction

    function automatic int nbeats(input logic [31:0] l);
        return int'(({32'd0, l} + 64'd63) / 64);
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic send_cmd(input bit is_rd, input logic [63:0] a, input logic [31:0] l);
        int n = 0;
        @(negedge ap_clk);
        if (is_rd) begin
            mif.s_axis_mem_read_cmd_tdata = {l, a};
            mif.s_axis_mem_read_cmd_tvalid = 1'b1;
            while (!mif.s_axis_mem_read_cmd_tready && n < 200) begin @(negedge ap_clk); n++; end
        end else begin
            mif.s_axis_mem_write_cmd_tdata = {l, a};
            mif.s_axis_mem_write_cmd_tvalid = 1'b1;
            while (!mif.s_axis_mem_write_cmd_tready && n < 200) begin @(negedge ap_clk); n++; end
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL cmd_accept rd=%0d: tready never seen within %0d cycles", is_rd, n);
        end
        @(posedge ap_clk); #1;
        mif.s_axis_mem_read_cmd_tvalid = 1'b0;
        mif.s_axis_mem_write_cmd_tvalid = 1'b0;
        if (is_rd) exp_rd++; else exp_wr++;
        if (a[5:0] != 6'd0) exp_un++;
    endtask

    // Writes len bytes of random data; rk selects random byte enables.
    task automatic wr_txn(input logic [63:0] a, input logic [31:0] l, input bit rk);
        int nb, idx, n;
        logic [511:0] d;
        logic [63:0]  k;
        nb = nbeats(l);
        idx = widx(a);
        send_cmd(1'b0, a, l);
        for (int i = 0; i < nb; i++) begin
            d = rand512();
            k = rk ? {$urandom, $urandom} : '1;
            @(negedge ap_clk);
            mif.s_axis_mem_write_data_tdata = d;
            mif.s_axis_mem_write_data_tkeep = k;
            mif.s_axis_mem_write_data_tvalid = 1'b1;
            n = 0;
            while (!mif.s_axis_mem_write_data_tready && n < 200) begin @(negedge ap_clk); n++; end
            vectors++;
            if (n >= 200) begin
                miscompares++;
                $display("FAIL wr_data_accept beat %0d: tready low for %0d cycles", i, n);
            end
            @(posedge ap_clk); #1;
            mif.s_axis_mem_write_data_tvalid = 1'b0;
            for (int b = 0; b < 64; b++)
                if (k[b]) model[(idx + i) % 1024][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Expected beats are taken from the model when the command is issued.
    task automatic rd_cmd(input logic [63:0] a, input logic [31:0] l);
        int nb, idx, rem;
        logic [63:0] one;
        beat_t b;
        one = 64'd1;
        nb = nbeats(l);
        idx = widx(a);
        for (int k = 0; k < nb; k++) begin
            rem = int'(l) - 64 * k;
            b.d = model[(idx + k) % 1024];
            b.l = (k == nb - 1);
            b.k = (rem >= 64) ? '1 : ((one << rem) - 64'd1);
            exp_q.push_back(b);
        end
        send_cmd(1'b1, a, l);
    endtask

    task automatic collect(input int n, input int bp, output int first);
        int    got = 0, cyc = 0;
        bit    held = 0, rdy;
        beat_t hb, e;
        first = -1;
        while (got < n && cyc < 3000) begin
            @(negedge ap_clk);
            cyc++;
            if (held) begin
                vectors++;
                if (mif.m_axis_mem_read_data_tvalid !== 1'b1 ||
                    mif.m_axis_mem_read_data_tdata !== hb.d ||
                    mif.m_axis_mem_read_data_tkeep !== hb.k ||
                    mif.m_axis_mem_read_data_tlast !== hb.l) begin
                    miscompares++;
                    $display("FAIL stall_hold beat %0d: vld=%b last=%b keep=%h, held keep=%h last=%b",
                             got, mif.m_axis_mem_read_data_tvalid, mif.m_axis_mem_read_data_tlast,
                             mif.m_axis_mem_read_data_tkeep, hb.k, hb.l);
                end
            end
            held = 0;
            if (mif.m_axis_mem_read_data_tvalid === 1'b1 && first < 0) first = cyc;
            rdy = ($urandom_range(0, 99) >= bp);
            mif.m_axis_mem_read_data_tready = rdy;
            if (mif.m_axis_mem_read_data_tvalid === 1'b1) begin
                if (!rdy) begin
                    held = 1;
                    hb.d = mif.m_axis_mem_read_data_tdata;
                    hb.k = mif.m_axis_mem_read_data_tkeep;
                    hb.l = mif.m_axis_mem_read_data_tlast;
                end else begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_beat: unexpected beat %0d", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (mif.m_axis_mem_read_data_tdata !== e.d ||
                            mif.m_axis_mem_read_data_tkeep !== e.k ||
                            mif.m_axis_mem_read_data_tlast !== e.l) begin
                            miscompares++;
                            $display("FAIL beat %0d: got keep=%h last=%b data=%h want keep=%h last=%b data=%h",
                                     got, mif.m_axis_mem_read_data_tkeep, mif.m_axis_mem_read_data_tlast,
                                     mif.m_axis_mem_read_data_tdata, e.k, e.l, e.d);
                        end
                    end
                    got++;
                end
            end
        end
        if (got < n) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_timeout: %0d beats of %0d", got, n);
        end
        @(posedge ap_clk); #1;
        mif.m_axis_mem_read_data_tready = 1'b0;
    endtask

    task automatic expect_idle_out(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge ap_clk);
            if (mif.m_axis_mem_read_data_tvalid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL %s: tvalid high %0d cycles, want 0", nm, seen);
        end
    endtask

    task automatic check_counts(input string nm);
        vectors++;
        if (wr_cmd_count !== exp_wr || rd_cmd_count !== exp_rd || unaligned_count !== exp_un) begin
            miscompares++;
            $display("FAIL %s counts: wr=%0d rd=%0d un=%0d want %0d %0d %0d", nm,
                     wr_cmd_count, rd_cmd_count, unaligned_count, exp_wr, exp_rd, exp_un);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ap_clk);
        vectors++;
        if (mif.s_axis_mem_write_cmd_tready !== 1'b0 || mif.s_axis_mem_write_data_tready !== 1'b0 ||
            mif.s_axis_mem_read_cmd_tready !== 1'b0 || mif.m_axis_mem_read_data_tvalid !== 1'b0 ||
            mif.m_axis_mem_read_data_tlast !== 1'b0 || mif.m_axis_mem_read_data_tkeep !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: wc=%b wd=%b rc=%b vld=%b last=%b keep=%h, want all 0",
                     mif.s_axis_mem_write_cmd_tready, mif.s_axis_mem_write_data_tready,
                     mif.s_axis_mem_read_cmd_tready, mif.m_axis_mem_read_data_tvalid,
                     mif.m_axis_mem_read_data_tlast, mif.m_axis_mem_read_data_tkeep);
        end
        check_counts("reset");
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        vectors++;
        if (mif.s_axis_mem_write_cmd_tready !== 1'b1 || mif.s_axis_mem_read_cmd_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready: wc=%b rc=%b want 1 1",
                     mif.s_axis_mem_write_cmd_tready, mif.s_axis_mem_read_cmd_tready);
        end
    endtask

    task automatic test_basic();
        int first;
        wr_txn(64'h1000, 128, 1'b0);
        rd_cmd(64'h1000, 128);
        collect(2, 0, first);
        vectors++;
        if (first != 3) begin
            miscompares++;
            $display("FAIL first_latency: tvalid at cycle %0d after handshake, want 3", first);
        end
        vectors++;
        if (wr_cmd_count !== 32'd1 || rd_cmd_count !== 32'd1) begin
            miscompares++;
            $display("FAIL basic_counts: wr=%0d rd=%0d want 1 1", wr_cmd_count, rd_cmd_count);
        end
        expect_idle_out("basic_no_dup", 4);
    endtask

    task automatic test_partial();
        int first;
        rd_cmd(64'h1000, 100);
        vectors++;
        if (exp_q[1].k !== 64'h0000000FFFFFFFFF) begin
            miscompares++;
            $display("FAIL partial_keep_model: %h want 0000000fffffffff", exp_q[1].k);
        end
        collect(2, 0, first);
    endtask

    task automatic test_backpressure();
        int first;
        wr_txn(64'h6400, 1024, 1'b0);
        wr_txn(64'h6400, 1024, 1'b1);
        rd_cmd(64'h6400, 1024);
        collect(16, 50, first);
        expect_idle_out("bp_no_dup", 4);
    endtask

    task automatic test_zero_len();
        int first;
        wr_txn(64'h2000, 0, 1'b0);
        @(negedge ap_clk);
        vectors++;
        if (mif.s_axis_mem_write_data_tready !== 1'b0 || mif.s_axis_mem_write_cmd_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_wr_idle: data_tready=%b cmd_tready=%b want 0 1",
                     mif.s_axis_mem_write_data_tready, mif.s_axis_mem_write_cmd_tready);
        end
        wr_txn(64'h2000, 64, 1'b0);
        rd_cmd(64'h2000, 64);
        collect(1, 0, first);
        rd_cmd(64'h2000, 0);
        expect_idle_out("zero_rd", 6);
        check_counts("zero_len");
    endtask

    task automatic test_wrap_unaligned();
        int first;
        wr_txn(64'h1_0003_FFC0, 128, 1'b0);
        rd_cmd(64'h1_0003_FFC0, 128);
        collect(2, 0, first);
        rd_cmd(64'h0, 64);
        collect(1, 0, first);
        wr_txn(64'h1005, 64, 1'b0);
        rd_cmd(64'h1000, 64);
        collect(1, 0, first);
        vectors++;
        if (unaligned_count !== 32'd1) begin
            miscompares++;
            $display("FAIL unaligned_count: %0d want 1", unaligned_count);
        end
        check_counts("wrap");
    endtask

    task automatic test_back_to_back();
        int first;
        wr_txn(64'h4000, 320, 1'b0);
        fork
            begin
                rd_cmd(64'h4000, 192);
                rd_cmd(64'h40C0, 100);
            end
            collect(5, 30, first);
        join
        expect_idle_out("b2b_no_dup", 4);
    endtask

    task automatic test_random();
        int first;
        logic [63:0] a;
        logic [31:0] l;
        for (int it = 0; it < 6; it++) begin
            a = {$urandom, $urandom};
            l = $urandom_range(1, 700);
            wr_txn(a, l, 1'b0);
            rd_cmd(a, l);
            collect(nbeats(l), $urandom_range(0, 60), first);
        end
        check_counts("random");
    endtask

    task automatic test_reset_mid();
        int got = 0, cyc = 0, first;
        beat_t e;
        wr_txn(64'h8000, 512, 1'b0);
        rd_cmd(64'h8000, 512);
        while (cyc < 200) begin
            @(negedge ap_clk);
            cyc++;
            mif.m_axis_mem_read_data_tready = 1'b1;
            if (mif.m_axis_mem_read_data_tvalid === 1'b1) begin
                if (got == 2) break;
                e = exp_q.pop_front();
                vectors++;
                if (mif.m_axis_mem_read_data_tdata !== e.d) begin
                    miscompares++;
                    $display("FAIL pre_reset beat %0d data mismatch", got);
                end
                got++;
            end
        end
        ap_rst_n = 1'b0;
        #1;
        vectors++;
        if (mif.m_axis_mem_read_data_tvalid !== 1'b0 || got != 2) begin
            miscompares++;
            $display("FAIL mid_reset_vld: tvalid=%b beats_before=%0d want 0 2",
                     mif.m_axis_mem_read_data_tvalid, got);
        end
        exp_q.delete();
        exp_wr = 0; exp_rd = 0; exp_un = 0;
        check_counts("mid_reset");
        @(posedge ap_clk); #1;
        mif.m_axis_mem_read_data_tready = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        expect_idle_out("post_reset_quiet", 4);
        rd_cmd(64'h8000, 64);
        collect(1, 0, first);
        check_counts("post_reset");
    endtask

    initial begin
        mif.s_axis_mem_write_cmd_tdata   = '0;
        mif.s_axis_mem_write_cmd_tvalid  = 1'b0;
        mif.s_axis_mem_write_data_tdata  = '0;
        mif.s_axis_mem_write_data_tkeep  = '0;
        mif.s_axis_mem_write_data_tvalid = 1'b0;
        mif.s_axis_mem_read_cmd_tdata    = '0;
        mif.s_axis_mem_read_cmd_tvalid   = 1'b0;
        mif.m_axis_mem_read_data_tready  = 1'b0;
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_zero_len();
        test_wrap_unaligned();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
